// File: rtl/tx_scheduler_pkg.sv
// Shared types and constants for the tx_scheduler slice.
package tx_sched_pkg;
  localparam int FRAME_BITS_DEF = 10;
  localparam int BYTE_W         = 8;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE, ABORT, GUARD} state_t;
endpackage

// File: rtl/tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request above ptr, wrapping.
// The pointer itself is owned by the instantiating scheduler.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     valid
);
  localparam int IDW = $clog2(N_REQ);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    // scan farthest-first so the nearest candidate after ptr is written last
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[IDW'(idx)]) begin
        winner = IDW'(idx);
        valid  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tx_scheduler.sv
// Round-robin transmit scheduler handing one byte frame at a time to the serializer.
// Build option: define TX_SCHED_GUARD_EN to insert GUARD_CYC idle cycles after each frame.
//
//  state | meaning
//  IDLE  | arbitrate; grant winner and latch its byte
//  LOAD  | pulse load to the serializer
//  SEND  | frame in flight, timeout counter running
//  DONE  | wait for serializer bit count to return to 0
//  ABORT | timeout hit, pulse err
//  GUARD | inter-frame gap (TX_SCHED_GUARD_EN only)
import tx_sched_pkg::*;

module tx_scheduler #(
  parameter int N_REQ      = 4,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int TIMEOUT    = 4096,
  parameter int GUARD_CYC  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      load,
  output logic                      transmiting,
  output logic [BYTE_W-1:0]         databyte,
  input  logic [3:0]                count,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  active_id,
  output logic                      err
);
  localparam int IDW = $clog2(N_REQ);
  localparam int TW  = $clog2(TIMEOUT);
  localparam int GW  = $clog2(GUARD_CYC) + 1;
  localparam logic [3:0] FB = 4'(FRAME_BITS);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_LOAD  = LOAD;
  localparam logic [2:0] S_SEND  = SEND;
  localparam logic [2:0] S_DONE  = DONE;
  localparam logic [2:0] S_ABORT = ABORT;
  localparam logic [2:0] S_GUARD = GUARD;

  logic [2:0]        state;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    win_idx;
  logic              win_valid;
  logic [BYTE_W-1:0] win_byte;
  logic [TW-1:0]     tcnt;
  logic [GW-1:0]     gcnt;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (win_idx),
    .valid  (win_valid)
  );

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win_idx == IDW'(i)) win_byte = req_data[BYTE_W*i +: BYTE_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= IDW'(N_REQ-1);
      grant       <= '0;
      load        <= 1'b0;
      transmiting <= 1'b0;
      databyte    <= '0;
      busy        <= 1'b0;
      active_id   <= '0;
      err         <= 1'b0;
      tcnt        <= '0;
      gcnt        <= '0;
    end else begin
      grant <= '0;
      load  <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            grant     <= N_REQ'(1) << win_idx;
            databyte  <= win_byte;
            active_id <= win_idx;
            ptr       <= win_idx;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          load        <= 1'b1;
          transmiting <= 1'b1;
          tcnt        <= TW'(TIMEOUT-1);
          state       <= S_SEND;
        end
        S_SEND: begin
          // a count past the frame length still ends the frame
          if (count >= FB) begin
            transmiting <= 1'b0;
            state       <= S_DONE;
          end else if (tcnt == '0) begin
            transmiting <= 1'b0;
            err         <= 1'b1;
            state       <= S_ABORT;
          end else begin
            tcnt <= tcnt - 1'b1;
          end
        end
        S_ABORT: state <= S_DONE;
        S_DONE: begin
          if (count == 4'd0) begin
            gcnt <= GW'(GUARD_CYC-1);
`ifdef TX_SCHED_GUARD_EN
            state <= S_GUARD;
`else
            busy  <= 1'b0;
            state <= S_IDLE;
`endif
          end
        end
        S_GUARD: begin
          if (gcnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        default: begin
          busy        <= 1'b0;
          transmiting <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end
endmodule
